// File: rtl/vita_frame_assembler_pkg.sv
// Shared types and sync-code constants for the VITA frame assembler.
// Holds the FSM state enum and the decoder's 8-bit sync words.
package vita_frame_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_LINE,
    ST_GAP
  } state_t;

  localparam logic [7:0] CODE_FS  = 8'hAA;
  localparam logic [7:0] CODE_FE  = 8'hCA;
  localparam logic [7:0] CODE_LS  = 8'h2A;
  localparam logic [7:0] CODE_LE  = 8'h4A;
  localparam logic [7:0] CODE_IMG = 8'h0D;

endpackage

// File: rtl/vita_pixel_hold.sv
// One-pixel hold register: delays each pixel until the next one (eol=0)
// or an end event (eol=1) arrives. Ports: push/flush in, emit + pix_* out.
import vita_frame_assembler_pkg::*;

module vita_pixel_hold #(
  parameter int DATA_W = 10,
  parameter int COL_W  = 12
) (
  input  logic              pclock,
  input  logic              reset,
  input  logic              push,
  input  logic              flush,
  input  logic              sof,
  input  logic [DATA_W-1:0] din,
  input  logic [COL_W-1:0]  col,
  input  logic [COL_W-1:0]  row,
  output logic              emit,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [DATA_W-1:0] pix_data,
  output logic [COL_W-1:0]  pix_col,
  output logic [COL_W-1:0]  pix_row
);

  logic              full;
  logic [DATA_W-1:0] h_data;
  logic [COL_W-1:0]  h_col;
  logic [COL_W-1:0]  h_row;

  // push and flush are mutually exclusive by strobe precedence
  assign emit = full & (push | flush);

  always_ff @(posedge pclock or negedge reset) begin
    if (!reset) begin
      full      <= 1'b0;
      h_data    <= '0;
      h_col     <= '0;
      h_row     <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_data  <= '0;
      pix_col   <= '0;
      pix_row   <= '0;
    end else begin
      pix_valid <= emit;
      pix_sof   <= emit & sof;
      pix_eol   <= emit & flush;
      if (emit) begin
        pix_data <= h_data;
        pix_col  <= h_col;
        pix_row  <= h_row;
      end
      if (push) begin
        full   <= 1'b1;
        h_data <= din;
        h_col  <= col;
        h_row  <= row;
      end else if (flush) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vita_frame_assembler.sv
// Assembles VITA sync-decoder strobes into a pixel stream with sof/eol,
// coordinates, window ID capture, line length and sticky error flags.
import vita_frame_assembler_pkg::*;

module vita_frame_assembler #(
  parameter int DATA_W      = 10,
  parameter int LINE_PIXELS = 1920,
  parameter int COL_W       = 12
) (
  input  logic              pclock,
  input  logic              reset,
  input  logic              FS,
  input  logic              FE,
  input  logic              LS,
  input  logic              LE,
  input  logic              IMG,
  input  logic              ID,
  input  logic              sync_bit,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [COL_W-1:0]  pix_col,
  output logic [COL_W-1:0]  pix_row,
  output logic [7:0]        window_id,
  output logic              frame_done,
  output logic [COL_W-1:0]  line_len,
  output logic              err_seq,
  output logic              err_len
);

  localparam logic [COL_W-1:0] CMAX = '1;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] row;
  logic [COL_W-1:0] row_nxt;
  logic             sof_pending;
  logic [7:0]       shift;
  logic             in_frame;
  logic             col_max;
  logic             len_bad;
  logic             push;
  logic             flush;
  logic             emit;

  assign in_frame = (state != ST_IDLE);
  assign col_max  = (col == CMAX);
  assign len_bad  = (32'(col) != LINE_PIXELS);
  assign row_nxt  = (row == CMAX) ? row : row + 1'b1;

  // any higher-priority strobe closes the held pixel; IMG only when alone
  assign flush = in_frame & (FS | FE | LE | LS);
  assign push  = (state == ST_IN_LINE) & IMG & ~col_max
               & ~(FS | FE | LE | LS);

  vita_pixel_hold #(
    .DATA_W(DATA_W),
    .COL_W (COL_W)
  ) u_hold (
    .pclock   (pclock),
    .reset    (reset),
    .push     (push),
    .flush    (flush),
    .sof      (sof_pending),
    .din      (data_in),
    .col      (col),
    .row      (row),
    .emit     (emit),
    .pix_valid(pix_valid),
    .pix_sof  (pix_sof),
    .pix_eol  (pix_eol),
    .pix_data (pix_data),
    .pix_col  (pix_col),
    .pix_row  (pix_row)
  );

  always_ff @(posedge pclock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      sof_pending <= 1'b0;
      shift       <= '0;
      window_id   <= '0;
      frame_done  <= 1'b0;
      line_len    <= '0;
      err_seq     <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      shift      <= {shift[6:0], sync_bit};
      frame_done <= 1'b0;
      if (ID) window_id <= {shift[6:0], sync_bit};
      if (emit) sof_pending <= 1'b0;
      if (FS) begin
        // restart from inside a frame is a sequence error
        state       <= ST_IN_LINE;
        col         <= '0;
        row         <= '0;
        sof_pending <= 1'b1;
        err_seq     <= in_frame;
        err_len     <= 1'b0;
      end else begin
        unique case (state)
          ST_IN_LINE: begin
            if (FE) begin
              state      <= ST_IDLE;
              line_len   <= col;
              frame_done <= 1'b1;
              if (len_bad) err_len <= 1'b1;
            end else if (LE) begin
              state    <= ST_GAP;
              line_len <= col;
              if (len_bad) err_len <= 1'b1;
            end else if (LS) begin
              err_seq <= 1'b1;
              row     <= row_nxt;
              col     <= '0;
            end else if (IMG) begin
              if (col_max) err_len <= 1'b1;
              else         col     <= col + 1'b1;
            end
          end
          ST_GAP: begin
            if (FE) begin
              state   <= ST_IDLE;
              err_seq <= 1'b1;
            end else if (LE) begin
              err_seq <= 1'b1;
            end else if (LS) begin
              state <= ST_IN_LINE;
              row   <= row_nxt;
              col   <= '0;
            end else if (IMG) begin
              err_seq <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vita_frame_assembler.sv
// Randomized + directed bench for vita_frame_assembler against a
// transaction-level reference model (LINE_PIXELS=4, COL_W=4).
module tb_vita_frame_assembler;

  localparam int DW = 10;
  localparam int CW = 4;
  localparam int LP = 4;
  localparam int MAXV = 15;

  logic pclock = 1'b0;
  logic reset;
  logic FS, FE, LS, LE, IMG, ID, sync_bit;
  logic [DW-1:0] data_in;
  logic [DW-1:0] pix_data;
  logic pix_valid, pix_sof, pix_eol;
  logic [CW-1:0] pix_col, pix_row;
  logic [7:0] window_id;
  logic frame_done;
  logic [CW-1:0] line_len;
  logic err_seq, err_len;

  vita_frame_assembler #(
    .DATA_W(DW), .LINE_PIXELS(LP), .COL_W(CW)
  ) dut (
    .pclock(pclock), .reset(reset),
    .FS(FS), .FE(FE), .LS(LS), .LE(LE), .IMG(IMG), .ID(ID),
    .sync_bit(sync_bit), .data_in(data_in),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_col(pix_col), .pix_row(pix_row),
    .window_id(window_id), .frame_done(frame_done),
    .line_len(line_len), .err_seq(err_seq), .err_len(err_len)
  );

  always #5 pclock = ~pclock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_eol   = 0;
  int n_sof   = 0;
  int n_done  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: frame phase, pixel bookkeeping, one-deep hold queue
  typedef struct {
    int d;
    int c;
    int r;
  } pix_t;

  pix_t held[$];
  int   phase;
  int   mrow, mcol, sofp, mshift;
  int   e_valid, e_sof, e_eol, e_data, e_col, e_row;
  int   e_done, e_len, e_seq, e_elen, e_wid;

  function automatic void model_reset();
    held.delete();
    phase = 0; mrow = 0; mcol = 0; sofp = 0; mshift = 0;
    e_valid = 0; e_sof = 0; e_eol = 0; e_data = 0; e_col = 0;
    e_row = 0; e_done = 0; e_len = 0; e_seq = 0; e_elen = 0;
    e_wid = 0;
  endfunction

  function automatic void m_emit(int eol);
    pix_t p;
    if (held.size() > 0) begin
      p = held.pop_front();
      e_valid = 1; e_sof = sofp; sofp = 0; e_eol = eol;
      e_data = p.d; e_col = p.c; e_row = p.r;
    end
  endfunction

  function automatic int sat(int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic void model_step(int fs, int fe, int ls, int le,
                                     int img, int d, int id, int sb);
    pix_t p;
    e_valid = 0; e_sof = 0; e_eol = 0; e_done = 0;
    if (id != 0) e_wid = ((mshift << 1) | sb) & 255;
    mshift = ((mshift << 1) | sb) & 255;
    if (fs != 0) begin
      if (phase != 0) begin
        m_emit(1);
        e_seq = 1;
      end else begin
        e_seq = 0;
      end
      e_elen = 0; phase = 1; mrow = 0; mcol = 0; sofp = 1;
    end else if (phase == 1) begin
      if (fe != 0 || le != 0) begin
        m_emit(1);
        e_len = mcol;
        if (mcol != LP) e_elen = 1;
        if (fe != 0) begin
          phase = 0; e_done = 1;
        end else begin
          phase = 2;
        end
      end else if (ls != 0) begin
        m_emit(1);
        e_seq = 1; mrow = sat(mrow + 1); mcol = 0;
      end else if (img != 0) begin
        if (mcol == MAXV) begin
          e_elen = 1;
        end else begin
          m_emit(0);
          p.d = d; p.c = mcol; p.r = mrow;
          held.push_back(p);
          mcol++;
        end
      end
    end else if (phase == 2) begin
      if (fe != 0) begin
        e_seq = 1; phase = 0;
      end else if (le != 0) begin
        e_seq = 1;
      end else if (ls != 0) begin
        phase = 1; mrow = sat(mrow + 1); mcol = 0;
      end else if (img != 0) begin
        e_seq = 1;
      end
    end
  endfunction

  task automatic compare_outputs();
    check("valid", 32'(pix_valid), e_valid);
    if (e_valid != 0) begin
      check("data", 32'(pix_data), e_data);
      check("col", 32'(pix_col), e_col);
      check("row", 32'(pix_row), e_row);
    end
    check("sof", 32'(pix_sof), e_sof);
    check("eol", 32'(pix_eol), e_eol);
    check("done", 32'(frame_done), e_done);
    check("line_len", 32'(line_len), e_len);
    check("err_seq", 32'(err_seq), e_seq);
    check("err_len", 32'(err_len), e_elen);
    check("window_id", 32'(window_id), e_wid);
    if (pix_valid) n_valid++;
    if (pix_eol) n_eol++;
    if (pix_sof) n_sof++;
    if (frame_done) n_done++;
  endtask

  task automatic drive(int fs, int fe, int ls, int le, int img,
                       int d, int id, int sb);
    @(negedge pclock);
    compare_outputs();
    FS = (fs != 0); FE = (fe != 0); LS = (ls != 0);
    LE = (le != 0); IMG = (img != 0); ID = (id != 0);
    sync_bit = (sb != 0);
    data_in = DW'(d);
    model_step(fs, fe, ls, le, img, d, id, sb);
  endtask

  task automatic s_fs();    drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic s_fe();    drive(0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic s_ls();    drive(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic s_le();    drive(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic s_img(int d); drive(0, 0, 0, 0, 1, d, 0, 0); endtask
  task automatic s_idle();  drive(0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic clear_inputs();
    FS = 0; FE = 0; LS = 0; LE = 0; IMG = 0; ID = 0;
    sync_bit = 0; data_in = '0;
  endtask

  task automatic do_reset();
    @(negedge pclock);
    compare_outputs();
    clear_inputs();
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_sof", 32'(pix_sof), 0);
    check("rst_eol", 32'(pix_eol), 0);
    check("rst_data", 32'(pix_data), 0);
    check("rst_col", 32'(pix_col), 0);
    check("rst_row", 32'(pix_row), 0);
    check("rst_wid", 32'(window_id), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_len", 32'(line_len), 0);
    check("rst_seq", 32'(err_seq), 0);
    check("rst_elen", 32'(err_len), 0);
    model_reset();
    repeat (2) @(negedge pclock);
    reset = 1'b1;
  endtask

  task automatic rnd_cycle(int fs, int fe, int ls, int le, int img);
    int id, sb;
    sb = int'($urandom_range(0, 1));
    id = ($urandom_range(0, 19) == 0) ? 1 : 0;
    drive(fs, fe, ls, le, img, int'($urandom_range(0, 1023)), id, sb);
  endtask

  task automatic noise();
    rnd_cycle(($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 5) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              int'($urandom_range(0, 1)));
  endtask

  initial begin
    int snap, nl, np;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check("init_valid", 32'(pix_valid), 0);
    check("init_seq", 32'(err_seq), 0);
    repeat (2) @(negedge pclock);
    reset = 1'b1;

    // two-line frame of 4 pixels each
    n_valid = 0; n_eol = 0; n_sof = 0; n_done = 0;
    s_fs();
    for (int i = 1; i <= 4; i++) s_img(i);
    s_le();
    s_ls();
    for (int i = 5; i <= 8; i++) s_img(i);
    s_fe();
    s_idle();
    s_idle();
    check("ex1_npix", n_valid, 8);
    check("ex1_neol", n_eol, 2);
    check("ex1_nsof", n_sof, 1);
    check("ex1_ndone", n_done, 1);
    check("ex1_seq", 32'(err_seq), 0);
    check("ex1_elen", 32'(err_len), 0);

    // short line
    s_fs();
    for (int i = 0; i < 3; i++) s_img(20 + i);
    s_le();
    s_idle();
    check("short_len", 32'(line_len), 3);
    check("short_elen", 32'(err_len), 1);
    s_fs();
    s_idle();
    check("short_clr", 32'(err_len), 0);

    // pixel in GAP, then FS restart inside a line
    s_img(30);
    s_le();
    s_img(31);
    s_idle();
    check("gap_seq", 32'(err_seq), 1);
    s_ls();
    s_img(40);
    s_img(41);
    s_fs();
    s_img(50);
    s_img(51);
    s_fe();
    s_idle();

    // FS with IMG, then window ID capture
    drive(1, 0, 0, 0, 1, 99, 0, 0);
    s_fe();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    s_idle();
    check("wid_b2", 32'(window_id), 32'h0000_00B2);

    // reset between two pixels of a line
    s_fs();
    s_img(60);
    s_img(61);
    do_reset();
    snap = n_valid;
    s_img(70);
    s_img(71);
    s_le();
    s_idle();
    s_idle();
    check("rst_nopix", n_valid - snap, 0);

    // randomized frames with noise and saturation
    for (int f = 0; f < 40; f++) begin
      rnd_cycle(1, 0, 0, 0, 0);
      nl = int'($urandom_range(1, 3));
      for (int l = 0; l < nl; l++) begin
        if (l > 0) begin
          if ($urandom_range(0, 1) == 1) rnd_cycle(0, 0, 0, 0, 0);
          rnd_cycle(0, 0, 1, 0, 0);
        end
        np = ($urandom_range(0, 7) == 0) ? 17 : int'($urandom_range(2, 6));
        for (int p = 0; p < np; p++) begin
          if ($urandom_range(0, 2) == 0) rnd_cycle(0, 0, 0, 0, 0);
          if ($urandom_range(0, 24) == 0) noise();
          rnd_cycle(0, 0, 0, 0, 1);
        end
        if (l < nl - 1) rnd_cycle(0, 0, 0, 1, 0);
        else if ($urandom_range(0, 4) == 0) rnd_cycle(0, 0, 0, 1, 0);
      end
      rnd_cycle(0, 1, 0, 0, 0);
      if ($urandom_range(0, 5) == 0) noise();
      if (f == 20) do_reset();
      rnd_cycle(0, 0, 0, 0, 0);
    end
    s_idle();
    s_idle();
    s_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
